// File: rtl/tinycpu_monitor.sv
// Run-time monitor for the tinycpu core: traces registers at each fetch boundary into a
// FIFO, counts retired instructions, detects the jump-to-self halt idiom and a fetch watchdog.
module tinycpu_monitor #(
  parameter int DW           = 8,
  parameter int TRACE_DEPTH  = 8,
  parameter int CNT_W        = 16,
  parameter int LOOP_CONFIRM = 1,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [2:0]          exec_state,
  input  logic [7:0]          instr,
  input  logic [DW-1:0]       rA,
  input  logic [DW-1:0]       rB,
  input  logic [DW-1:0]       rM,
  input  logic [DW-1:0]       rP,
  output logic                trace_vld,
  input  logic                trace_rdy,
  output logic [4*DW-1:0]     trace_data,
  output logic                trace_ovf,
  output logic [CNT_W-1:0]    instr_count,
  output logic                halted,
  output logic [DW-1:0]       loop_pc,
  output logic                wdog_trip
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int OW = $clog2(TRACE_DEPTH + 1);
  localparam int LW = $clog2(LOOP_CONFIRM + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  localparam logic [OW-1:0] FULL_LVL = OW'(TRACE_DEPTH);
  localparam logic [LW-1:0] LC_MAX   = LW'(LOOP_CONFIRM);
  localparam logic [WW-1:0] WC_MAX   = WW'(WDOG_CYCLES);
  localparam logic [WW-1:0] WC_TRIP  = WW'(WDOG_CYCLES - 1);

  logic [4*DW-1:0]  r_mem [TRACE_DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [OW-1:0]    r_level;
  logic             r_traceOvf;
  logic [CNT_W-1:0] r_instrCount;
  logic             r_halted;
  logic [DW-1:0]    r_loopPc;
  logic             r_wdogTrip;
  logic [LW-1:0]    r_lc;
  logic [DW-1:0]    r_lm;
  logic [WW-1:0]    r_wc;

  logic             w_fetch;
  logic             w_exec;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wrEn;
  logic             w_drop;
  logic [DW-1:0]    w_rPm1;
  logic             w_cand;
  logic [LW-1:0]    w_lcNext;
  logic             w_halt;
  logic             w_unusedInstr;

  assign w_fetch = (exec_state == 3'd0);
  assign w_exec  = (exec_state == 3'd2);
  assign w_push  = w_fetch && !r_halted;
  assign w_pop   = (r_level != '0) && trace_rdy;
  assign w_full  = (r_level == FULL_LVL);
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign w_wrEn  = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign w_rPm1        = rP - 1'b1;
  assign w_cand        = w_exec && (instr[7:6] == 2'b11) && (w_rPm1 == rM);
  assign w_unusedInstr = ^instr[5:0];

  always_comb begin
    w_lcNext = r_lc;
    if (w_exec) begin
      if (w_cand) begin
        if ((r_lc == '0) || (rM == r_lm)) begin
          w_lcNext = (r_lc == LC_MAX) ? r_lc : r_lc + 1'b1;
        end else begin
          w_lcNext = LW'(1);
        end
      end else begin
        w_lcNext = '0;
      end
    end
  end

  assign w_halt = w_cand && (w_lcNext == LC_MAX) && !r_halted;

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wrEn && !clear) begin
      r_mem[r_wrPtr] <= {rA, rB, rM, rP};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_traceOvf <= 1'b0;
    end else if (clear) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_traceOvf <= 1'b0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_wrEn && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_wrEn && w_pop) begin
        r_level <= r_level - 1'b1;
      end
      if (w_drop) begin
        r_traceOvf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instrCount <= '0;
    end else if (clear) begin
      r_instrCount <= '0;
    end else if (w_push && (r_instrCount != '1)) begin
      r_instrCount <= r_instrCount + 1'b1;
    end
  end

  // Halt detection: lm remembers the last candidate's rM so only a repeated self-jump confirms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lc     <= '0;
      r_lm     <= '0;
      r_halted <= 1'b0;
      r_loopPc <= '0;
    end else if (clear) begin
      r_lc     <= '0;
      r_lm     <= '0;
      r_halted <= 1'b0;
      r_loopPc <= '0;
    end else begin
      r_lc <= w_lcNext;
      if (w_cand) begin
        r_lm <= rM;
      end
      if (w_halt) begin
        r_halted <= 1'b1;
        r_loopPc <= rM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wc       <= '0;
      r_wdogTrip <= 1'b0;
    end else if (clear) begin
      r_wc       <= '0;
      r_wdogTrip <= 1'b0;
    end else if (!r_halted) begin
      if (w_fetch) begin
        r_wc <= '0;
      end else begin
        if (r_wc != WC_MAX) begin
          r_wc <= r_wc + 1'b1;
        end
        if (r_wc == WC_TRIP) begin
          r_wdogTrip <= 1'b1;
        end
      end
    end
  end

  assign trace_vld   = (r_level != '0);
  assign trace_data  = trace_vld ? r_mem[r_rdPtr] : '0;
  assign trace_ovf   = r_traceOvf;
  assign instr_count = r_instrCount;
  assign halted      = r_halted;
  assign loop_pc     = r_loopPc;
  assign wdog_trip   = r_wdogTrip;

endmodule

// File: tb/tb_tinycpu_monitor.sv
// Scoreboard bench for tinycpu_monitor: expected trace entries are queued at stimulus time
// and popped by an independent monitor whenever the DUT hands over a FIFO entry.
module tb_tinycpu_monitor;

  localparam int DW = 8;
  localparam int TD = 8;
  localparam int CW = 16;
  localparam int LC = 2;
  localparam int WD = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic [2:0]      exec_state;
  logic [7:0]      instr;
  logic [DW-1:0]   rA, rB, rM, rP;
  logic            trace_rdy;
  logic            trace_vld;
  logic [4*DW-1:0] trace_data;
  logic            trace_ovf;
  logic [CW-1:0]   instr_count;
  logic            halted;
  logic [DW-1:0]   loop_pc;
  logic            wdog_trip;

  int errors = 0;
  int checks = 0;
  logic [4*DW-1:0] expQ[$];

  tinycpu_monitor #(
    .DW(DW), .TRACE_DEPTH(TD), .CNT_W(CW), .LOOP_CONFIRM(LC), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .exec_state(exec_state), .instr(instr),
    .rA(rA), .rB(rB), .rM(rM), .rP(rP),
    .trace_vld(trace_vld), .trace_rdy(trace_rdy), .trace_data(trace_data),
    .trace_ovf(trace_ovf), .instr_count(instr_count), .halted(halted),
    .loop_pc(loop_pc), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drives one cycle of CPU taps from posedge+1 through the next edge; queues the expected entry.
  task automatic applyStimulus(input logic [2:0] st, input logic [7:0] ins,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] m, input logic [7:0] p,
                               input bit expectPush);
    exec_state = st;
    instr      = ins;
    rA = a; rB = b; rM = m; rP = p;
    if (expectPush) expQ.push_back({a, b, m, p});
    @(posedge clk);
    #1;
  endtask

  task automatic applyClear();
    clear      = 1'b1;
    exec_state = 3'd1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    expQ.delete();
  endtask

  task automatic drainAll(input string name);
    int budget = 64;
    exec_state = 3'd1;
    trace_rdy  = 1'b1;
    while (expQ.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    trace_rdy = 1'b0;
    checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "_vldLow"}, 32'(trace_vld), 32'd0);
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && trace_vld === 1'b1 && trace_rdy === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedEntry: got %0h expected no entry", trace_data);
        end else begin
          logic [4*DW-1:0] expEntry;
          expEntry = expQ.pop_front();
          checkOutput("traceData", trace_data, expEntry);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end of test expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; exec_state = 3'd1; instr = 8'h00;
    rA = '0; rB = '0; rM = '0; rP = '0; trace_rdy = 1'b0;
    #1 reset = 1'b0;
    #11;
    checkOutput("rstVld", 32'(trace_vld), 32'd0);
    checkOutput("rstData", trace_data, 32'd0);
    checkOutput("rstCount", 32'(instr_count), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
    checkOutput("rstOvf", 32'(trace_ovf), 32'd0);
    checkOutput("rstWdog", 32'(wdog_trip), 32'd0);
    checkOutput("rstLoopPc", 32'(loop_pc), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Three fetches, held, then drained in order.
    for (int i = 1; i <= 3; i++) applyStimulus(3'd0, 8'h00, 8'(i), 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("t1Count", 32'(instr_count), 32'd3);
    checkOutput("t1Vld", 32'(trace_vld), 32'd1);
    checkOutput("t1Head", trace_data, 32'h01000000);
    applyStimulus(3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t1HeadHeld", trace_data, 32'h01000000);
    drainAll("t1");

    // Fill to full, push+pop at full, then a dropped push.
    for (int i = 0; i < TD; i++)
      applyStimulus(3'd0, 8'h00, 8'(8'h10 + i), 8'(8'hA0 + i), 8'(i), 8'h55, 1'b1);
    checkOutput("t2OvfFull", 32'(trace_ovf), 32'd0);
    checkOutput("t2Count", 32'(instr_count), 32'd11);
    trace_rdy = 1'b1;
    applyStimulus(3'd0, 8'h00, 8'h18, 8'hA8, 8'h08, 8'h55, 1'b1);
    trace_rdy = 1'b0;
    checkOutput("t2OvfPushPop", 32'(trace_ovf), 32'd0);
    applyStimulus(3'd0, 8'h00, 8'h19, 8'hA9, 8'h09, 8'h55, 1'b0);
    checkOutput("t2OvfDrop", 32'(trace_ovf), 32'd1);
    checkOutput("t2CountDrop", 32'(instr_count), 32'd13);
    checkOutput("t2Head", trace_data, 32'h11A10155);
    drainAll("t2");
    applyClear();
    checkOutput("t2ClrOvf", 32'(trace_ovf), 32'd0);
    checkOutput("t2ClrCount", 32'(instr_count), 32'd0);

    // Watchdog trips exactly on the WD-th non-fetch edge.
    for (int i = 0; i < WD - 1; i++) applyStimulus(3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t3WdogBefore", 32'(wdog_trip), 32'd0);
    applyStimulus(3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t3WdogTrip", 32'(wdog_trip), 32'd1);
    applyClear();
    checkOutput("t3WdogClr", 32'(wdog_trip), 32'd0);

    // Halt confirmed after two identical self-jumps; nothing pushed while halted.
    applyStimulus(3'd0, 8'h00, 8'h61, 8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(3'd0, 8'h00, 8'h62, 8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h10, 8'h12, 1'b0);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h10, 8'h12, 1'b0);
    checkOutput("t4NoHalt", 32'(halted), 32'd0);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h10, 8'h11, 1'b0);
    checkOutput("t4HaltFirst", 32'(halted), 32'd0);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h10, 8'h11, 1'b0);
    checkOutput("t4Halted", 32'(halted), 32'd1);
    checkOutput("t4LoopPc", 32'(loop_pc), 32'h10);
    applyStimulus(3'd0, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(3'd0, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t4CountFrozen", 32'(instr_count), 32'd2);
    for (int i = 0; i < WD + 4; i++) applyStimulus(3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t4WdogHalted", 32'(wdog_trip), 32'd0);
    drainAll("t4");
    applyClear();
    checkOutput("t4ClrHalted", 32'(halted), 32'd0);
    checkOutput("t4ClrLoopPc", 32'(loop_pc), 32'd0);

    // Changed rM restarts the count, a non-jump clears it, and rP=0/rM=FF wraps.
    applyStimulus(3'd0, 8'h00, 8'h71, 8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h20, 8'h21, 1'b0);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h30, 8'h31, 1'b0);
    checkOutput("t5NewPc", 32'(halted), 32'd0);
    applyStimulus(3'd2, 8'h80, 8'h00, 8'h00, 8'h30, 8'h31, 1'b0);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h30, 8'h31, 1'b0);
    checkOutput("t5NonJump", 32'(halted), 32'd0);
    applyStimulus(3'd2, 8'hC5, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0);
    checkOutput("t5WrapFirst", 32'(halted), 32'd0);
    applyStimulus(3'd2, 8'hC5, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0);
    checkOutput("t5WrapHalted", 32'(halted), 32'd1);
    checkOutput("t5WrapLoopPc", 32'(loop_pc), 32'hFF);
    applyStimulus(3'd0, 8'h00, 8'h72, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t5CountFrozen", 32'(instr_count), 32'd1);
    applyClear();

    // Asynchronous reset between edges with a populated FIFO and halt set.
    for (int i = 0; i < 4; i++) applyStimulus(3'd0, 8'h00, 8'(8'h81 + i), 8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h10, 8'h11, 1'b0);
    applyStimulus(3'd2, 8'hC0, 8'h00, 8'h00, 8'h10, 8'h11, 1'b0);
    checkOutput("t6PreHalted", 32'(halted), 32'd1);
    checkOutput("t6PreCount", 32'(instr_count), 32'd4);
    exec_state = 3'd1;
    #3 reset = 1'b0;
    #1;
    expQ.delete();
    checkOutput("t6RstVld", 32'(trace_vld), 32'd0);
    checkOutput("t6RstHalted", 32'(halted), 32'd0);
    checkOutput("t6RstCount", 32'(instr_count), 32'd0);
    checkOutput("t6RstLoopPc", 32'(loop_pc), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(3'd0, 8'h00, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b1);
    checkOutput("t6Recover", 32'(instr_count), 32'd1);
    drainAll("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
